// File: rtl/verlet_pkg.sv
// verlet_pkg: shared FSM state, fixed-point defaults and saturating add for the Verlet node.
package verlet_pkg;
  typedef enum logic [1:0] {IDLE, INTEGRATE, CONSTRAIN, DONE} state_t;
  localparam int FRAC_DEF = 8;
  localparam int GRAVITY_DEF = 51;
  // Clamps a signed sum into the unsigned range [0, 2^w-1]; w must not exceed 32.
  function automatic logic [31:0] sat_add(input logic signed [33:0] s, input int w);
    logic signed [33:0] mx;
    mx = (34'sd1 <<< w) - 34'sd1;
    return s < 0 ? 32'd0 : s > mx ? mx[31:0] : s[31:0];
  endfunction
endpackage

// File: rtl/verlet_node_if.sv
// verlet_node_if: sequencer-to-node step handshake, correction stream and position readout.
interface verlet_node_if #(parameter int WIDTH = 16);
  logic step_start;
  logic pin_en;
  logic corr_valid;
  logic [WIDTH-1:0] corr_dx;
  logic [WIDTH-1:0] corr_dy;
  logic corr_last;
  logic corr_ready;
  logic busy;
  logic step_done;
  logic [WIDTH-1:0] x_pos;
  logic [WIDTH-1:0] y_pos;
  modport master (output step_start, pin_en, corr_valid, corr_dx, corr_dy, corr_last,
                  input corr_ready, busy, step_done, x_pos, y_pos);
  modport slave (input step_start, pin_en, corr_valid, corr_dx, corr_dy, corr_last,
                 output corr_ready, busy, step_done, x_pos, y_pos);
endinterface

// File: rtl/verlet_axis.sv
// verlet_axis: one axis of a Verlet particle (integrate, correct, pin, saturate).
// Optional velocity damping under VERLET_DAMPING_EN.
module verlet_axis import verlet_pkg::*; #(
  parameter int WIDTH = 16,
  parameter int BASE = 0,
  parameter int ACC = 0,
  parameter int DAMP_SHIFT = 2
) (
  input  logic clk,
  input  logic reset,
  input  logic integ,
  input  logic corr_en,
  input  logic pin,
  input  logic signed [WIDTH-1:0] corr,
  output logic [WIDTH-1:0] pos
);
  localparam logic [WIDTH-1:0] BASE_W = WIDTH'(BASE);
  localparam logic signed [WIDTH+1:0] ACC_W = (WIDTH+2)'(ACC);
  logic [WIDTH-1:0] prev;
  logic signed [WIDTH+1:0] v, vd, sum_i, sum_c;
  always_comb begin
    v = $signed({2'b00, pos}) - $signed({2'b00, prev});
`ifdef VERLET_DAMPING_EN
    vd = v - (v >>> DAMP_SHIFT);
`else
    vd = v;
`endif
    sum_i = $signed({2'b00, pos}) + vd + ACC_W;
    sum_c = $signed({2'b00, pos}) + (WIDTH+2)'(corr);
  end
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      pos  <= BASE_W;
      prev <= BASE_W;
    end else if (integ) begin
      prev <= pin ? BASE_W : pos;
      pos  <= pin ? BASE_W : WIDTH'(sat_add(34'(sum_i), WIDTH));
    end else if (corr_en && !pin) begin
      pos <= WIDTH'(sat_add(34'(sum_c), WIDTH));
    end
  end
endmodule

// File: rtl/verlet_node.sv
// verlet_node: one Verlet particle with step FSM and streamed constraint corrections.
// Define VERLET_DAMPING_EN to damp the implicit velocity by v>>>DAMP_SHIFT.
module verlet_node import verlet_pkg::*; #(
  parameter int WIDTH = 16,
  parameter int FRAC = FRAC_DEF,
  parameter int BASE_X = 51200,
  parameter int BASE_Y = 0,
  parameter int GRAVITY = GRAVITY_DEF,
  parameter int DAMP_SHIFT = 2
) (
  input logic clk,
  input logic reset,
  verlet_node_if.slave bus
);
  state_t st;
  logic integ, corr_en;
  assign integ = st == INTEGRATE;
  assign corr_en = bus.corr_ready && bus.corr_valid;
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      st             <= IDLE;
      bus.busy       <= 1'b0;
      bus.corr_ready <= 1'b0;
      bus.step_done  <= 1'b0;
    end else begin
      case (st)
        IDLE: if (bus.step_start) begin
          st       <= INTEGRATE;
          bus.busy <= 1'b1;
        end
        INTEGRATE: begin
          st             <= CONSTRAIN;
          bus.corr_ready <= 1'b1;
        end
        CONSTRAIN: if (bus.corr_valid && bus.corr_last) begin
          st             <= DONE;
          bus.corr_ready <= 1'b0;
          bus.step_done  <= 1'b1;
        end
        default: begin
          st            <= IDLE;
          bus.step_done <= 1'b0;
          bus.busy      <= 1'b0;
        end
      endcase
    end
  end
  verlet_axis #(.WIDTH(WIDTH), .BASE(BASE_X), .ACC(0), .DAMP_SHIFT(DAMP_SHIFT)) u_x (
    .clk(clk), .reset(reset), .integ(integ), .corr_en(corr_en), .pin(bus.pin_en),
    .corr(bus.corr_dx), .pos(bus.x_pos)
  );
  verlet_axis #(.WIDTH(WIDTH), .BASE(BASE_Y), .ACC(GRAVITY), .DAMP_SHIFT(DAMP_SHIFT)) u_y (
    .clk(clk), .reset(reset), .integ(integ), .corr_en(corr_en), .pin(bus.pin_en),
    .corr(bus.corr_dy), .pos(bus.y_pos)
  );
endmodule

// File: doc/verlet_node.md
# verlet_node

Parametrised Verlet-integration particle for the cloth/rope simulator. It is the successor to the fixed 8-bit node: widths and fixed-point format are configurable, the position update is the correct Verlet form, and it adds runtime pinning, saturating arithmetic and a streamed constraint-correction phase. Each instance holds one particle and sits in the node array under the simulation sequencer, which runs `step_start` / `step_done` handshakes per time step.

## Interface
- `WIDTH`, 16: position width, unsigned fixed point.
- `FRAC`, 8: fractional bits of positions, corrections and `GRAVITY`.
- `BASE_X`, 51200: reset/pin X (200.0 in Q8.8).
- `BASE_Y`, 0: reset/pin Y.
- `GRAVITY`, 51: per-step Y acceleration term (≈0.2 in Q8.8), unsigned.
- `DAMP_SHIFT`, 2: velocity damping shift; used only with `VERLET_DAMPING_EN`.
- `clk` in 1: single clock, rising edge.
- `reset` in 1: asynchronous, active-high reset.
- `step_start` in 1: start one time step; sampled only in IDLE.
- `pin_en` in 1: node is pinned at (`BASE_X`,`BASE_Y`); sampled in INTEGRATE and CONSTRAIN.
- `corr_valid` in 1: correction beat valid.
- `corr_dx`, `corr_dy` in WIDTH: signed two's-complement correction deltas.
- `corr_last` in 1: final correction beat of this step.
- `corr_ready` out 1: node accepts corrections (high only in CONSTRAIN).
- `busy` out 1: high in any state other than IDLE.
- `step_done` out 1: one-cycle pulse at end of step.
- `x_pos`, `y_pos` out WIDTH: current position (registered).

## Operation
- State registers: `x`, `y`, `px`, `py` (WIDTH each); FSM states IDLE, INTEGRATE, CONSTRAIN, DONE.
- Reset: `x`=`px`=`BASE_X`, `y`=`py`=`BASE_Y`, state IDLE, `busy`=0, `step_done`=0, `corr_ready`=0.
- IDLE: `step_start`=1 → INTEGRATE. Otherwise hold.
- INTEGRATE (1 cycle): `px`<=`x`, `py`<=`y`, `x`<=sat(`x`+vx), `y`<=sat(`y`+vy+`GRAVITY`), with vx=`x`−`px` and vy=`y`−`py`. Then → CONSTRAIN.
- Pinned in INTEGRATE: all four registers are loaded with the base values instead.
- CONSTRAIN: `corr_ready`=1. On each `corr_valid` beat: `x`<=sat(`x`+`corr_dx`), `y`<=sat(`y`+`corr_dy`). `px`/`py` are untouched, so corrections implicitly alter velocity.
- Pinned in CONSTRAIN: beats are accepted and discarded.
- `corr_valid`&&`corr_last` → DONE. The last beat is applied. `corr_last` without `corr_valid` is ignored.
- DONE (1 cycle): `step_done`=1, then → IDLE.
- Arithmetic: sums are formed signed at WIDTH+2 bits. sat(): result <0 → 0; result >2^WIDTH−1 → 2^WIDTH−1. There is no wrap-around anywhere.
- `step_start` while `busy` is ignored; it is not queued.
- Reset mid-step: immediate return to IDLE with base positions. No `step_done` is emitted.

## Timing
- `step_start` sampled at edge k → INTEGRATE during cycle k..k+1.
- Integrated positions visible on `x_pos`/`y_pos` after edge k+1; CONSTRAIN starts the same cycle.
- Each accepted beat is visible one cycle after its edge.
- Minimum step (`corr_last` on the first CONSTRAIN cycle): `step_done` high during cycle after edge k+2. `step_start` is accepted again at edge k+4.
- All outputs are registered. There is no combinational path from inputs to outputs.

## Configuration
- `VERLET_DAMPING_EN` defined: vx, vy are replaced by v−(v>>>`DAMP_SHIFT`) (arithmetic shift) before the sum.
- `VERLET_DAMPING_EN` undefined: undamped; `DAMP_SHIFT` is unused. Port list is identical in both builds.

## Structure
- Shared package `verlet_pkg`:
  - FSM state enum.
  - Default fixed-point constants (`FRAC`, `GRAVITY` value).
  - Saturating-add function parametrised by WIDTH.
- Sub-module `verlet_axis`: one axis (`pos`/`prev` registers, integrate, correct, pin, saturate). Instantiated twice, with Y receiving `GRAVITY` and X receiving 0.
- FSM and handshake live in `verlet_node`.

## Test plan
- Reset → `x_pos`=51200, `y_pos`=0, `busy`=0, `corr_ready`=0, `step_done`=0.
- Three steps, no damping, each with a single zero beat plus `corr_last` → `y_pos` = 51, 153, 306; `x_pos` = 51200; `step_done` is a single pulse 3 cycles after each `step_start`.
- `pin_en`=1, step with `corr_dx`=+1000 → positions stay 51200/0, beat is consumed, `step_done` still pulses.
- Saturation via corrections from y=0: +32767, +32767, +32767 → 32767, 65534, 65535. `corr_dx`=−32768 twice from 51200 → 18432, then 0.
- `step_start` held during CONSTRAIN → ignored. Assert `reset` mid-CONSTRAIN → IDLE, base positions, no `step_done`.
- With `VERLET_DAMPING_EN`, `DAMP_SHIFT`=2: free-fall steps → `y_pos` = 51, then 51+39+51 = 141.
